// File: rtl/doorlock_pkg.sv
// Shared types and status-display encodings for the keypad door-lock controller.
// Included first so the timer and top can import it.
package doorlock_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StEntry   = 3'd1,
        StOpen    = 3'd2,
        StProgram = 3'd3,
        StLockout = 3'd4
    } state_e;

    localparam logic [1:0] SEG_ENTER  = 2'b00;
    localparam logic [1:0] SEG_OPEN   = 2'b01;
    localparam logic [1:0] SEG_LOCKED = 2'b10;
    localparam logic [1:0] SEG_ALARM  = 2'b11;

    function automatic logic [1:0] seg_of(input state_e s);
        logic [1:0] seg;
        case (s)
            StEntry, StProgram: seg = SEG_ENTER;
            StOpen:             seg = SEG_OPEN;
            StLockout:          seg = SEG_ALARM;
            default:            seg = SEG_LOCKED;
        endcase
        return seg;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/doorlock_timer.sv
// Loadable down-counter shared by the open window, lockout and entry-inactivity timeouts.
// Stops at zero; expired_o flags the cycle whose clock edge takes the count from 1 to 0.
module doorlock_timer #(
    parameter int unsigned Width = 11
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] value_i,
    output logic             expired_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Driven from the register only, so the FSM can use it to pick the next load.
    assign expired_o = (cnt_q == Width'(1));

endmodule

// File: rtl/keypad_doorlock.sv
// Keypad door-lock controller: digit capture, code compare, timed open window, attempt
// counting with lockout, entry inactivity timeout and passcode reprogramming while open.
module keypad_doorlock
    import doorlock_pkg::*;
#(
    parameter int unsigned                  DIGITS       = 4,
    parameter int unsigned                  DIGIT_W      = 4,
    parameter logic [DIGITS*DIGIT_W-1:0]    PASSCODE     = 16'h1234,
    parameter int unsigned                  MAX_FAIL     = 3,
    parameter int unsigned                  OPEN_CYC     = 500,
    parameter int unsigned                  LOCKOUT_CYC  = 1000,
    parameter int unsigned                  ENTRY_TO_CYC = 2000
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          key_valid_i,
    input  logic [DIGIT_W-1:0]            key_val_i,
    input  logic                          key_enter_i,
    input  logic                          key_clear_i,
    input  logic                          set_code_i,
    output logic                          door_open_o,
    output logic [2:0]                    state_out_o,
    output logic [1:0]                    seg_out_o,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt_o
);

    localparam int unsigned CodeW  = DIGITS * DIGIT_W;
    localparam int unsigned CntW   = $clog2(DIGITS + 1);
    localparam int unsigned FailW  = $clog2(MAX_FAIL + 1);
    localparam int unsigned TmrMax = max3(OPEN_CYC, LOCKOUT_CYC, ENTRY_TO_CYC);
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);

    localparam logic [CntW-1:0]  CntFull = CntW'(DIGITS);
    localparam logic [FailW-1:0] FailMax = FailW'(MAX_FAIL);

    state_e           state_q, state_d;
    logic [CodeW-1:0] buf_q, buf_d;
    logic [CodeW-1:0] code_q, code_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [FailW-1:0] fail_q, fail_d;
    logic             door_q, door_d;
    logic [1:0]       seg_q, seg_d;

    logic             restart;
    logic             tmr_load;
    logic [TmrW-1:0]  tmr_value;
    logic             tmr_expired;
    logic [CodeW-1:0] buf_shift;
    logic [FailW-1:0] fail_inc;
    logic             code_match;

    assign buf_shift  = (buf_q << DIGIT_W) | CodeW'(key_val_i);
    assign fail_inc   = fail_q + FailW'(1);
    assign code_match = (cnt_q == CntFull) && (buf_q == code_q);

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        restart = 1'b0;

        case (state_q)
            StIdle: begin
                if (key_valid_i && !key_clear_i && !key_enter_i && !set_code_i) begin
                    buf_d   = CodeW'(key_val_i);
                    cnt_d   = CntW'(1);
                    state_d = StEntry;
                end
            end

            StEntry, StProgram: begin
                if (key_clear_i) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (key_enter_i) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (state_q == StProgram) begin
                        if (cnt_q == CntFull) begin
                            code_d = buf_q;
                        end
                    end else if (code_match) begin
                        fail_d  = '0;
                        state_d = StOpen;
                    end else begin
                        fail_d = fail_inc;
                        if (fail_inc == FailMax) begin
                            state_d = StLockout;
                        end
                    end
                end else if (key_valid_i && !set_code_i) begin
                    // Any keypress counts as activity, even once the buffer is full.
                    restart = 1'b1;
                    if (cnt_q != CntFull) begin
                        buf_d = buf_shift;
                        cnt_d = cnt_q + CntW'(1);
                    end
                end else if (tmr_expired) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end

            StOpen: begin
                if (key_enter_i && !key_clear_i) begin
                    state_d = StIdle;
                end else if (set_code_i && !key_clear_i) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = StProgram;
                end else if (tmr_expired) begin
                    state_d = StIdle;
                end
            end

            StLockout: begin
                if (tmr_expired) begin
                    fail_d  = '0;
                    state_d = StIdle;
                end
            end

            default: begin
                buf_d   = '0;
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase

        door_d = (state_d == StOpen);
        seg_d  = seg_of(state_d);
    end

    // Timer is reloaded on every state entry and on each keypress during an entry.
    always_comb begin
        tmr_load = (state_d != state_q) || restart;
        case (state_d)
            StOpen:             tmr_value = TmrW'(OPEN_CYC);
            StLockout:          tmr_value = TmrW'(LOCKOUT_CYC);
            StEntry, StProgram: tmr_value = TmrW'(ENTRY_TO_CYC);
            default:            tmr_value = '0;
        endcase
    end

    doorlock_timer #(
        .Width (TmrW)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (tmr_load),
        .value_i   (tmr_value),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            buf_q   <= '0;
            code_q  <= PASSCODE;
            cnt_q   <= '0;
            fail_q  <= '0;
            door_q  <= 1'b0;
            seg_q   <= SEG_LOCKED;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            door_q  <= door_d;
            seg_q   <= seg_d;
        end
    end

    assign door_open_o = door_q;
    assign state_out_o = state_q;
    assign seg_out_o   = seg_q;
    assign fail_cnt_o  = fail_q;

endmodule

// File: tb/tb_keypad_doorlock.sv
// Directed bench for keypad_doorlock with default parameters; inputs change and outputs are
// sampled on the falling clock edge.
module tb_keypad_doorlock;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_val = 4'd0;
    logic       key_enter = 1'b0;
    logic       key_clear = 1'b0;
    logic       set_code = 1'b0;
    logic       door_open;
    logic [2:0] state_out;
    logic [1:0] seg_out;
    logic [1:0] fail_cnt;

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    keypad_doorlock u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .key_valid_i (key_valid),
        .key_val_i   (key_val),
        .key_enter_i (key_enter),
        .key_clear_i (key_clear),
        .set_code_i  (set_code),
        .door_open_o (door_open),
        .state_out_o (state_out),
        .seg_out_o   (seg_out),
        .fail_cnt_o  (fail_cnt)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        key_valid = 1'b0;
        key_enter = 1'b0;
        key_clear = 1'b0;
        set_code = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic press_key(input logic [3:0] d);
        key_valid = 1'b1;
        key_val = d;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic press_enter();
        key_enter = 1'b1;
        @(negedge clk);
        key_enter = 1'b0;
    endtask

    task automatic press_set();
        set_code = 1'b1;
        @(negedge clk);
        set_code = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 0; i < 4; i++) begin
            press_key(c[15-4*i -: 4]);
        end
        press_enter();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (state_out !== 3'd0) $display("FAIL reset_state: got %0d want 0", state_out);
        else passed++;
        total++;
        if (seg_out !== 2'b10) $display("FAIL reset_seg: got %b want 10", seg_out);
        else passed++;
        total++;
        if (door_open !== 1'b0 || fail_cnt !== 2'd0)
            $display("FAIL reset_door_fail: got %b/%0d want 0/0", door_open, fail_cnt);
        else passed++;
    endtask

    task automatic test_open();
        int cnt;
        press_key(4'd1);
        total++;
        if (state_out !== 3'd1 || seg_out !== 2'b00)
            $display("FAIL entry_state: got %0d/%b want 1/00", state_out, seg_out);
        else passed++;
        press_key(4'd2);
        press_key(4'd3);
        press_key(4'd4);
        press_enter();
        total++;
        if (door_open !== 1'b1 || seg_out !== 2'b01 || state_out !== 3'd2)
            $display("FAIL open_outputs: got %b/%b/%0d want 1/01/2", door_open, seg_out, state_out);
        else passed++;
        cnt = 0;
        while (door_open === 1'b1 && cnt < 600) begin
            cnt++;
            @(negedge clk);
        end
        total++;
        if (cnt !== 500) $display("FAIL open_width: got %0d want 500", cnt);
        else passed++;
        total++;
        if (state_out !== 3'd0 || seg_out !== 2'b10)
            $display("FAIL open_expire: got %0d/%b want 0/10", state_out, seg_out);
        else passed++;
    endtask

    task automatic test_lockout();
        int cnt;
        enter_code(16'h1235);
        total++;
        if (fail_cnt !== 2'd1 || state_out !== 3'd0)
            $display("FAIL wrong1: got %0d/%0d want 1/0", fail_cnt, state_out);
        else passed++;
        enter_code(16'h1235);
        total++;
        if (fail_cnt !== 2'd2 || state_out !== 3'd0)
            $display("FAIL wrong2: got %0d/%0d want 2/0", fail_cnt, state_out);
        else passed++;
        enter_code(16'h1235);
        total++;
        if (state_out !== 3'd4 || seg_out !== 2'b11 || fail_cnt !== 2'd3)
            $display("FAIL lockout_entry: got %0d/%b/%0d want 4/11/3", state_out, seg_out, fail_cnt);
        else passed++;
        enter_code(16'h1234);
        total++;
        if (state_out !== 3'd4 || door_open !== 1'b0)
            $display("FAIL lockout_ignore: got %0d/%b want 4/0", state_out, door_open);
        else passed++;
        // Five lockout cycles were spent on the ignored keypresses.
        cnt = 0;
        while (state_out === 3'd4 && cnt < 1100) begin
            cnt++;
            @(negedge clk);
        end
        total++;
        if (cnt !== 995) $display("FAIL lockout_len: got %0d want 995", cnt);
        else passed++;
        total++;
        if (state_out !== 3'd0 || fail_cnt !== 2'd0)
            $display("FAIL lockout_exit: got %0d/%0d want 0/0", state_out, fail_cnt);
        else passed++;
        enter_code(16'h1234);
        total++;
        if (state_out !== 3'd2 || door_open !== 1'b1)
            $display("FAIL post_lockout_open: got %0d/%b want 2/1", state_out, door_open);
        else passed++;
        press_enter();
        total++;
        if (state_out !== 3'd0 || door_open !== 1'b0)
            $display("FAIL relock: got %0d/%b want 0/0", state_out, door_open);
        else passed++;
    endtask

    task automatic test_short_entry();
        press_key(4'd1);
        press_key(4'd2);
        press_key(4'd3);
        press_enter();
        total++;
        if (fail_cnt !== 2'd1 || state_out !== 3'd0)
            $display("FAIL short_entry: got %0d/%0d want 1/0", fail_cnt, state_out);
        else passed++;
        press_key(4'd1);
        press_key(4'd2);
        press_key(4'd3);
        press_key(4'd4);
        press_key(4'd9);
        press_enter();
        total++;
        if (state_out !== 3'd2 || fail_cnt !== 2'd0)
            $display("FAIL extra_digit: got %0d/%0d want 2/0", state_out, fail_cnt);
        else passed++;
        press_enter();
    endtask

    task automatic test_clear_timeout();
        int cnt;
        press_key(4'd5);
        press_enter();
        press_key(4'd1);
        press_key(4'd2);
        key_enter = 1'b1;
        key_clear = 1'b1;
        @(negedge clk);
        key_enter = 1'b0;
        key_clear = 1'b0;
        total++;
        if (state_out !== 3'd0 || fail_cnt !== 2'd1)
            $display("FAIL clear_priority: got %0d/%0d want 0/1", state_out, fail_cnt);
        else passed++;
        press_key(4'd1);
        press_key(4'd2);
        cnt = 0;
        while (state_out === 3'd1 && cnt < 2100) begin
            cnt++;
            @(negedge clk);
        end
        total++;
        if (cnt !== 2000) $display("FAIL timeout_len: got %0d want 2000", cnt);
        else passed++;
        total++;
        if (state_out !== 3'd0 || seg_out !== 2'b10 || fail_cnt !== 2'd1)
            $display("FAIL timeout_exit: got %0d/%b/%0d want 0/10/1", state_out, seg_out, fail_cnt);
        else passed++;
        // A stale 1,2 in the buffer would turn 3,4 into the correct code.
        press_key(4'd3);
        press_key(4'd4);
        press_enter();
        total++;
        if (state_out !== 3'd0 || fail_cnt !== 2'd2)
            $display("FAIL timeout_flushed: got %0d/%0d want 0/2", state_out, fail_cnt);
        else passed++;
        enter_code(16'h1234);
        press_enter();
    endtask

    task automatic test_program();
        enter_code(16'h1234);
        press_set();
        total++;
        if (state_out !== 3'd3 || door_open !== 1'b0 || seg_out !== 2'b00)
            $display("FAIL program_entry: got %0d/%b/%b want 3/0/00", state_out, door_open, seg_out);
        else passed++;
        enter_code(16'h9876);
        total++;
        if (state_out !== 3'd0 || fail_cnt !== 2'd0)
            $display("FAIL program_done: got %0d/%0d want 0/0", state_out, fail_cnt);
        else passed++;
        enter_code(16'h1234);
        total++;
        if (state_out !== 3'd0 || fail_cnt !== 2'd1)
            $display("FAIL old_code_rejected: got %0d/%0d want 0/1", state_out, fail_cnt);
        else passed++;
        enter_code(16'h9876);
        total++;
        if (state_out !== 3'd2 || fail_cnt !== 2'd0)
            $display("FAIL new_code_opens: got %0d/%0d want 2/0", state_out, fail_cnt);
        else passed++;
        press_set();
        press_key(4'd5);
        press_key(4'd5);
        do_reset();
        enter_code(16'h9876);
        total++;
        if (state_out !== 3'd0 || fail_cnt !== 2'd1)
            $display("FAIL reset_drops_new: got %0d/%0d want 0/1", state_out, fail_cnt);
        else passed++;
        enter_code(16'h1234);
        total++;
        if (state_out !== 3'd2 || door_open !== 1'b1)
            $display("FAIL reset_restores_code: got %0d/%b want 2/1", state_out, door_open);
        else passed++;
        press_enter();
    endtask

    task automatic test_async_reset();
        enter_code(16'h1234);
        repeat (10) @(negedge clk);
        total++;
        if (door_open !== 1'b1) $display("FAIL pre_async_open: got %b want 1", door_open);
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (door_open !== 1'b0 || state_out !== 3'd0 || seg_out !== 2'b10 || fail_cnt !== 2'd0)
            $display("FAIL async_reset: got %b/%0d/%b/%0d want 0/0/10/0",
                     door_open, state_out, seg_out, fail_cnt);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (state_out !== 3'd0 || door_open !== 1'b0)
            $display("FAIL after_async: got %0d/%b want 0/0", state_out, door_open);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_open();
        test_lockout();
        test_short_entry();
        test_clear_timeout();
        test_program();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
